cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_pkg.sv | 39 +++
 rtl/seq_decode.sv | 33 +++
 rtl/cpu_sequencer.sv | 120 ++++++++++++
 tb/tb_cpu_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared sequencer types: FSM state encodings, opcodes, jump kinds, instruction field positions.
// Pure definitions; no latency or flow control.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        JK_NONE = 2'd0,
        JK_JMP  = 2'd1,
        JK_JZ   = 2'd2,
        JK_JNZ  = 2'd3
    } jump_kind_t;

    localparam logic [2:0] OP_MOV = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_JMP = 3'b011;
    localparam logic [2:0] OP_JZ  = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_CMP = 3'b110;  // shares its encoding with JNZ; dest selects which
    localparam logic [2:0] OP_JNZ = 3'b110;

    localparam logic [1:0] JUMP_DEST = 2'b11;

    localparam int OPC_MSB  = 7;
    localparam int OPC_LSB  = 5;
    localparam int DEST_MSB = 4;
    localparam int DEST_LSB = 3;
    localparam int SRC_MSB  = 2;
    localparam int SRC_LSB  = 0;

endpackage

// File: rtl/seq_decode.sv
// Combinational instruction classifier: jump kind, register-write intent, jump target.
// Zero latency, no flow control.
import cpu_pkg::*;

module seq_decode (
    input  logic [7:0] ir,
    output logic       is_jump,
    output jump_kind_t jump_kind,
    output logic       writes_reg,
    output logic [3:0] target
);

    logic [2:0] opcode;
    logic [1:0] dest;

    always_comb begin
        opcode    = ir[OPC_MSB:OPC_LSB];
        dest      = ir[DEST_MSB:DEST_LSB];
        jump_kind = JK_NONE;
        if (dest == JUMP_DEST) begin
            case (opcode)
                OP_JMP:  jump_kind = JK_JMP;
                OP_JZ:   jump_kind = JK_JZ;
                OP_JNZ:  jump_kind = JK_JNZ;
                default: jump_kind = JK_NONE;
            endcase
        end
        is_jump    = (jump_kind != JK_NONE);
        writes_reg = !is_jump && (opcode != OP_CMP);
        target     = {1'b0, ir[SRC_MSB:SRC_LSB]};
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/WRITEBACK with run, single-step and halt control.
// Four cycles per instruction; run/step/halt requests are only honoured at instruction boundaries.
import cpu_pkg::*;

module cpu_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       step_req,
    input  logic       halt_req,
    input  logic [7:0] instr,
    input  logic       zero_in,
    output logic [3:0] pc_out,
    output logic [7:0] ir_out,
    output logic       reg_we,
    output logic       jump_taken,
    output logic       step_ack,
    output logic       halted,
    output logic       zero_flag,
    output logic [2:0] state_out,
    output logic [7:0] instr_count
);

    state_t     state;
    logic       free_run;
    logic       step_mode;
    logic       taken;
    logic       take_now;
    logic       is_jump;
    logic       writes_reg;
    jump_kind_t jump_kind;
    logic [3:0] target;

    seq_decode u_decode (
        .ir         (ir_out),
        .is_jump    (is_jump),
        .jump_kind  (jump_kind),
        .writes_reg (writes_reg),
        .target     (target)
    );

    // Jumps never touch zero_flag, so the latched value is the one left by the previous instruction.
    always_comb begin
        take_now = 1'b0;
        case (jump_kind)
            JK_JMP:  take_now = 1'b1;
            JK_JZ:   take_now = zero_flag;
            JK_JNZ:  take_now = !zero_flag;
            default: take_now = 1'b0;
        endcase
    end

    assign state_out = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            pc_out      <= 4'd0;
            ir_out      <= 8'd0;
            zero_flag   <= 1'b0;
            instr_count <= 8'd0;
            halted      <= 1'b0;
            reg_we      <= 1'b0;
            jump_taken  <= 1'b0;
            step_ack    <= 1'b0;
            free_run    <= 1'b0;
            step_mode   <= 1'b0;
            taken       <= 1'b0;
        end else begin
            reg_we     <= 1'b0;
            jump_taken <= 1'b0;
            step_ack   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (halt_req) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end else if (run) begin
                        state     <= ST_FETCH;
                        free_run  <= 1'b1;
                        step_mode <= 1'b0;
                    end else if (step_req) begin
                        state     <= ST_FETCH;
                        free_run  <= 1'b0;
                        step_mode <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    ir_out <= instr;
                    state  <= ST_DECODE;
                end
                ST_DECODE: state <= ST_EXECUTE;
                ST_EXECUTE: begin
                    if (!is_jump)
                        zero_flag <= zero_in;
                    taken      <= take_now;
                    reg_we     <= writes_reg;
                    jump_taken <= take_now;
                    step_ack   <= step_mode;
                    state      <= ST_WRITEBACK;
                end
                ST_WRITEBACK: begin
                    pc_out      <= taken ? target : pc_out + 4'd1;
                    instr_count <= instr_count + 8'd1;
                    if ((taken && jump_kind == JK_JMP && target == pc_out) || halt_req) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end else if (free_run && run) begin
                        state <= ST_FETCH;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed programs plus random ROM images against an instruction-level model.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       reset, run, step_req, halt_req, zero_in;
    logic [7:0] instr, ir_out, instr_count;
    logic [3:0] pc_out;
    logic       reg_we, jump_taken, step_ack, halted, zero_flag;
    logic [2:0] state_out;

    logic [7:0] rom [16];
    bit         ztab [256];

    int vectors = 0;
    int miscompares = 0;

    // Instruction-level reference state
    int m_pc, m_cnt;
    bit m_z, m_halted;

    localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC = 3, S_WB = 4, S_HALT = 5;

    cpu_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .step_req    (step_req),
        .halt_req    (halt_req),
        .instr       (instr),
        .zero_in     (zero_in),
        .pc_out      (pc_out),
        .ir_out      (ir_out),
        .reg_we      (reg_we),
        .jump_taken  (jump_taken),
        .step_ack    (step_ack),
        .halted      (halted),
        .zero_flag   (zero_flag),
        .state_out   (state_out),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    assign instr   = rom[pc_out];
    assign zero_in = ztab[ir_out];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_mov();
        for (int a = 0; a < 16; a++) rom[a] = 8'b000_00_001;
        for (int k = 0; k < 256; k++) ztab[k] = 1'($urandom_range(1));
    endtask

    task automatic gen_rom(input int jump_pct);
        logic [7:0] w;
        for (int a = 0; a < 16; a++) begin
            w = 8'($urandom);
            if (int'($urandom_range(99)) < jump_pct) begin
                w[4:3] = 2'b11;
                case ($urandom_range(2))
                    0:       w[7:5] = 3'b011;
                    1:       w[7:5] = 3'b100;
                    default: w[7:5] = 3'b110;
                endcase
            end else if (w[4:3] == 2'b11 && (w[7:5] == 3'b011 || w[7:5] == 3'b100 || w[7:5] == 3'b110)) begin
                w[4:3] = 2'b01;
            end
            rom[a] = w;
        end
        for (int k = 0; k < 256; k++) ztab[k] = 1'($urandom_range(1));
    endtask

    task automatic do_reset();
        run = 1'b0; step_req = 1'b0; halt_req = 1'b0;
        reset = 1'b1;
        tick();
        chk("rst_state", 32'(state_out), S_IDLE);
        chk("rst_pc", 32'(pc_out), 0);
        chk("rst_ir", 32'(ir_out), 0);
        chk("rst_z", 32'(zero_flag), 0);
        chk("rst_cnt", 32'(instr_count), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_outs", {29'd0, reg_we, jump_taken, step_ack}, 0);
        reset = 1'b0;
        m_pc = 0; m_cnt = 0; m_z = 1'b0; m_halted = 1'b0;
    endtask

    // Free-runs n instructions from IDLE, dropping run during the last one so the block returns to IDLE.
    task automatic run_prog(input int n);
        logic [7:0] ir;
        logic [2:0] op, src;
        logic [1:0] dst;
        bit jmp, tk, we, slf;
        run = 1'b1;
        for (int i = 0; i < n && !m_halted; i++) begin
            tick();
            chk("fetch_state", 32'(state_out), S_FETCH);
            chk("fetch_pc", 32'(pc_out), 32'(m_pc));
            chk("fetch_cnt", 32'(instr_count), 32'(m_cnt % 256));
            chk("fetch_z", 32'(zero_flag), 32'(m_z));
            if (i == n - 1) run = 1'b0;
            tick();
            chk("dec_ir", 32'(ir_out), 32'(rom[m_pc]));
            chk("dec_we", 32'(reg_we), 0);
            tick();
            chk("exe_state", 32'(state_out), S_EXEC);
            chk("exe_we", 32'(reg_we), 0);
            tick();
            ir  = rom[m_pc];
            op  = ir[7:5]; dst = ir[4:3]; src = ir[2:0];
            jmp = (dst == 2'b11) && (op == 3'b011 || op == 3'b100 || op == 3'b110);
            tk  = jmp && (op == 3'b011 || (op == 3'b100 && m_z) || (op == 3'b110 && !m_z));
            we  = !jmp && (op != 3'b110);
            slf = tk && (op == 3'b011) && (int'(src) == m_pc);
            if (!jmp) m_z = ztab[ir];
            chk("wb_state", 32'(state_out), S_WB);
            chk("wb_we", 32'(reg_we), 32'(we));
            chk("wb_jump", 32'(jump_taken), 32'(tk));
            chk("wb_stepack", 32'(step_ack), 0);
            chk("wb_z", 32'(zero_flag), 32'(m_z));
            m_pc  = tk ? int'(src) : (m_pc + 1) % 16;
            m_cnt = m_cnt + 1;
            if (slf) begin
                m_halted = 1'b1;
                run = 1'b0;
                tick();
                chk("selfhalt_state", 32'(state_out), S_HALT);
                chk("selfhalt_flag", 32'(halted), 1);
                chk("selfhalt_cnt", 32'(instr_count), 32'(m_cnt % 256));
                for (int c = 0; c < 20; c++) begin
                    tick();
                    chk("halt_pc", 32'(pc_out), 32'(m_pc));
                    chk("halt_we", 32'(reg_we), 0);
                end
            end
        end
        if (!m_halted) begin
            tick();
            chk("end_state", 32'(state_out), S_IDLE);
            chk("end_pc", 32'(pc_out), 32'(m_pc));
            chk("end_cnt", 32'(instr_count), 32'(m_cnt % 256));
        end
        run = 1'b0;
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; step_req = 1'b0; halt_req = 1'b0;
        fill_mov();

        // MOV R0,#1 ; ADD R0,R0
        do_reset();
        rom[0] = 8'b000_00_001;
        rom[1] = 8'b001_00_000;
        run_prog(2);
        chk("two_instr_cnt", 32'(instr_count), 2);

        // JMP 2 at pc 5
        do_reset();
        fill_mov();
        rom[5] = 8'b011_11_010;
        run_prog(7);

        // CMP then JZ 6 / JNZ 6 with both zero outcomes
        for (int k = 0; k < 4; k++) begin
            do_reset();
            fill_mov();
            rom[0] = 8'b110_00_000;
            rom[1] = (k < 2) ? 8'b100_11_110 : 8'b110_11_110;
            ztab[8'b110_00_000] = (k % 2 == 0);
            run_prog(3);
        end

        // PC wrap 15 -> 0
        do_reset();
        fill_mov();
        run_prog(17);

        // Self-loop JMP 3 halts; reset recovers
        do_reset();
        fill_mov();
        rom[3] = 8'b011_11_011;
        run_prog(10);
        do_reset();

        // Single step
        fill_mov();
        rom[0] = 8'b001_01_010;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        chk("step_fetch", 32'(state_out), S_FETCH);
        tick(); tick(); tick();
        chk("step_ack_wb", 32'(step_ack), 1);
        chk("step_we_wb", 32'(reg_we), 1);
        tick();
        chk("step_idle", 32'(state_out), S_IDLE);
        chk("step_ack_drop", 32'(step_ack), 0);
        chk("step_cnt", 32'(instr_count), 1);
        chk("step_pc", 32'(pc_out), 1);

        // halt_req in IDLE
        do_reset();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("idle_halt_state", 32'(state_out), S_HALT);
        chk("idle_halt_flag", 32'(halted), 1);

        // halt_req mid-instruction lets it retire
        do_reset();
        run = 1'b1;
        tick(); tick();
        halt_req = 1'b1;
        tick(); tick();
        chk("midhalt_we", 32'(reg_we), 1);
        tick();
        halt_req = 1'b0; run = 1'b0;
        chk("midhalt_state", 32'(state_out), S_HALT);
        chk("midhalt_pc", 32'(pc_out), 1);
        chk("midhalt_cnt", 32'(instr_count), 1);

        // Reset during EXECUTE
        do_reset();
        run = 1'b1;
        tick(); tick(); tick();
        chk("pre_rst_state", 32'(state_out), S_EXEC);
        chk("pre_rst_we", 32'(reg_we), 0);
        do_reset();
        tick();
        chk("post_rst_state", 32'(state_out), S_IDLE);
        chk("post_rst_we", 32'(reg_we), 0);

        // Random programs
        for (int p = 0; p < 6; p++) begin
            do_reset();
            gen_rom(25);
            run_prog(30);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
